hex_scroll_viewer: RTL and testbench
====================================

Name: hex_scroll_viewer

Overview:
Parametrised scrolling hex viewer for multiplexed common-anode 7-segment displays. It shows a DIGITS-wide window of nibbles from a DATA_W-bit word. The window moves in nibble steps under left/right button control, or steps by itself in auto-scroll mode. It sits between the debounced button inputs and the board display, and exports the current window index so that memory-browsing logic can follow it.

Parameters:
DATA_W, 32, width of displayed word; must be a multiple of 4 and at least 4*DIGITS.
DIGITS, 4, number of physical 7-segment digits multiplexed.
REFRESH_DIV, 100000, clk cycles per digit-multiplex step.
AUTO_DIV, 50000000, clk cycles per auto-scroll step.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
btn_right  in  1  debounced level; rising edge = scroll toward higher nibbles.
btn_left  in  1  debounced level; rising edge = scroll toward lower nibbles.
btn_center  in  1  debounced level; rising edge = toggle MANUAL/AUTO mode.
data  in  DATA_W  word being displayed; sampled live, no latching.
anode  out  DIGITS  digit enables, active-low, one-hot-low.
seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
dp  out  1  decimal point, active-low.
scroll_idx  out  IW=$clog2(DATA_W/4)  index of nibble shown on digit 0 (rightmost).
auto_mode  out  1  1 = AUTO, 0 = MANUAL.

Behaviour:
- Reset values: scroll_idx=0, auto_mode=0, digit_sel=0, both dividers=0, anode=all 1, seg=7'h7F, dp=1, edge-detector history regs=0.
- Edge detect: registered previous level per button. A pulse fires when level=1 and prev=0. Holding a button gives exactly one pulse.
- MAX_IDX = DATA_W/4 - DIGITS.
- Digit d shows nibble data[4*(scroll_idx+d) +: 4].
- MANUAL mode:
  - Right pulse: scroll_idx+1, saturating at MAX_IDX.
  - Left pulse: scroll_idx-1, saturating at 0.
  - Right and left pulses in the same cycle: no change.
- AUTO mode:
  - Auto divider counts 0..AUTO_DIV-1. At terminal count scroll_idx+1, wrapping from MAX_IDX to 0.
  - Left/right pulses are ignored.
- Center pulse:
  - Toggles auto_mode and clears the auto divider.
  - scroll_idx is kept.
  - Center plus left/right pulses in the same cycle: only the toggle takes effect.
- Mux:
  - Refresh divider counts 0..REFRESH_DIV-1. At terminal count digit_sel increments, wrapping DIGITS-1 -> 0.
  - anode, seg and dp are registered: one-cycle latency from digit_sel, scroll_idx or data change.
  - anode has exactly one bit low (bit digit_sel) in every cycle after the first post-reset cycle.
- Hex encoding: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- DIGITS*4==DATA_W means MAX_IDX=0: scroll_idx stays 0 in both modes.
- Reset mid-scroll or mid-refresh returns every register to its reset value on the next edge.

Optional Feature:
Macro HEX_SCROLL_DP_EN.
- Defined: dp=0 on digit DIGITS-1 when scroll_idx<MAX_IDX (more data to the left). dp=0 on digit 0 when scroll_idx>0 (more data to the right). dp=1 elsewhere. Same one-cycle registered latency as seg.
- Undefined: dp tied to 1.
- The port exists in both builds.

Decomposition:
- Shared package seg7_pkg:
  - SEG_BLANK=7'h7F.
  - The 16-entry hex-to-segment constant table/function.
  - Typedef for active-low segment vector.
- One sub-module, btn_edge_det: prev register plus rising-edge pulse, instantiated three times.
- Dividers, scroll FSM and mux stay in the top module.

Test Plan:
Use DATA_W=32, DIGITS=4, REFRESH_DIV=4, AUTO_DIV=16 throughout.
1. Reset, data=32'h0123ABCF, step through digits with anode 1110,1101,1011,0111 -> seg 0E,46,03,08. scroll_idx=0.
2. Five right pulses -> scroll_idx 1,2,3,4,4 (saturates). digit0 then shows nibble 4 -> seg 19 for data=32'h76543210. Five left pulses -> idx back to 0, stays 0.
3. Hold btn_right high 50 cycles -> exactly one increment. Right and left rising in the same cycle -> idx unchanged.
4. Center pulse -> auto_mode=1. idx advances every 16 cycles: 0,1,2,3,4,0. Right pulses ignored. Second center pulse -> auto_mode=0, idx frozen.
5. Assert rst mid-auto at idx=3, digit_sel=2 -> next cycle idx=0, auto_mode=0, anode=1111, seg=7F.
6. Build with HEX_SCROLL_DP_EN, idx=2 -> dp=0 while anode=0111 and while anode=1110, dp=1 on other digits. Without the macro dp is always 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the hex scroll viewer.
//   seg_t      : active-low segment vector {g,f,e,d,c,b,a}
//   SEG_BLANK  : all segments off
//   mode_t     : scroll mode state (manual / auto)
//   hex_to_seg : nibble to active-low segment pattern
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  typedef enum logic {
    ModeManual = 1'b0,
    ModeAuto   = 1'b1
  } mode_t;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for a debounced button level.
//   clk   : system clock
//   rst   : synchronous active-high reset (clears history)
//   level : debounced button level
//   pulse : one-cycle high when level is 1 and was 0 last cycle
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign pulse = level & ~prev_q;

endmodule

// File: rtl/hex_scroll_viewer.sv
// Scrolling hex viewer for multiplexed common-anode 7-segment displays.
// Shows a DIGITS-wide window of nibbles from data; the window moves by button
// (manual mode) or by itself every AUTO_DIV cycles (auto mode).
//   clk        : system clock
//   rst        : synchronous active-high reset
//   btn_right  : rising edge scrolls toward higher nibbles (manual mode)
//   btn_left   : rising edge scrolls toward lower nibbles (manual mode)
//   btn_center : rising edge toggles manual/auto mode
//   data       : word being displayed, sampled live
//   anode      : active-low digit enables, one-hot-low
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   dp         : active-low decimal point
//   scroll_idx : index of the nibble shown on digit 0 (rightmost)
//   auto_mode  : 1 = auto scroll, 0 = manual
// Build option: define HEX_SCROLL_DP_EN to light the decimal points as
// "more data" markers at the window edges; otherwise dp stays off.
module hex_scroll_viewer
  import seg7_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned AUTO_DIV    = 50000000,
  localparam int unsigned NIBBLES    = DATA_W / 4,
  localparam int unsigned IW         = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_right,
  input  logic              btn_left,
  input  logic              btn_center,
  input  logic [DATA_W-1:0] data,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [IW-1:0]     scroll_idx,
  output logic              auto_mode
);

  localparam int unsigned MAX_IDX = NIBBLES - DIGITS;
  localparam int unsigned RW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned AW      = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int unsigned SW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IW-1:0] IdxMax      = IW'(MAX_IDX);
  localparam logic [RW-1:0] RefreshLast = RW'(REFRESH_DIV - 1);
  localparam logic [AW-1:0] AutoLast    = AW'(AUTO_DIV - 1);
  localparam logic [SW-1:0] DigitLast   = SW'(DIGITS - 1);

  // Button edge detection
  logic right_pulse;
  logic left_pulse;
  logic center_pulse;

  btn_edge_det u_edge_right (
    .clk   (clk),
    .rst   (rst),
    .level (btn_right),
    .pulse (right_pulse)
  );

  btn_edge_det u_edge_left (
    .clk   (clk),
    .rst   (rst),
    .level (btn_left),
    .pulse (left_pulse)
  );

  btn_edge_det u_edge_center (
    .clk   (clk),
    .rst   (rst),
    .level (btn_center),
    .pulse (center_pulse)
  );

  // Scroll mode FSM, auto divider and window index
  mode_t         mode_q;
  logic [AW-1:0] auto_cnt_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= ModeManual;
      auto_cnt_q <= '0;
      idx_q      <= '0;
    end else if (center_pulse) begin
      // Mode toggle wins over any simultaneous scroll request.
      mode_q     <= (mode_q == ModeAuto) ? ModeManual : ModeAuto;
      auto_cnt_q <= '0;
    end else begin
      case (mode_q)
        ModeAuto: begin
          if (auto_cnt_q == AutoLast) begin
            auto_cnt_q <= '0;
            idx_q      <= (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
          end else begin
            auto_cnt_q <= auto_cnt_q + AW'(1);
          end
        end
        default: begin
          auto_cnt_q <= '0;
          // Opposing pulses in the same cycle cancel.
          if (right_pulse && !left_pulse && idx_q != IdxMax) begin
            idx_q <= idx_q + IW'(1);
          end else if (left_pulse && !right_pulse && idx_q != '0) begin
            idx_q <= idx_q - IW'(1);
          end
        end
      endcase
    end
  end

  assign scroll_idx = idx_q;
  assign auto_mode  = (mode_q == ModeAuto);

  // Digit multiplex divider
  logic [RW-1:0] refresh_cnt_q;
  logic [SW-1:0] digit_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      digit_sel_q   <= '0;
    end else if (refresh_cnt_q == RefreshLast) begin
      refresh_cnt_q <= '0;
      digit_sel_q   <= (digit_sel_q == DigitLast) ? '0 : digit_sel_q + SW'(1);
    end else begin
      refresh_cnt_q <= refresh_cnt_q + RW'(1);
    end
  end

  // Output decode; registered below for one cycle of latency
  logic [IW-1:0]     nib_pos;
  logic [IW+1:0]     bit_pos;
  logic [DIGITS-1:0] anode_d;
  seg_t              seg_d;
  logic              dp_d;

  assign nib_pos = idx_q + IW'(digit_sel_q);
  assign bit_pos = {nib_pos, 2'b00};

  always_comb begin
    anode_d              = '1;
    anode_d[digit_sel_q] = 1'b0;
    seg_d                = hex_to_seg(data[bit_pos +: 4]);
`ifdef HEX_SCROLL_DP_EN
    dp_d = 1'b1;
    // Leftmost dot: more nibbles above the window; rightmost: more below.
    if (digit_sel_q == DigitLast && idx_q < IdxMax) begin
      dp_d = 1'b0;
    end
    if (digit_sel_q == '0 && idx_q != '0) begin
      dp_d = 1'b0;
    end
`else
    dp_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode <= '1;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      anode <= anode_d;
      seg   <= seg_d;
      dp    <= dp_d;
    end
  end

endmodule

// File: tb/tb_hex_scroll_viewer.sv
module tb_hex_scroll_viewer;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_right;
  logic        btn_left;
  logic        btn_center;
  logic [31:0] data;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  scroll_idx;
  logic        auto_mode;

  // Second instance where the word exactly fills the display (MAX_IDX = 0)
  logic [3:0]  s_anode;
  logic [6:0]  s_seg;
  logic        s_dp;
  logic [1:0]  s_idx;
  logic        s_auto;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_scroll_viewer #(
    .DATA_W      (32),
    .DIGITS      (4),
    .REFRESH_DIV (4),
    .AUTO_DIV    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_right  (btn_right),
    .btn_left   (btn_left),
    .btn_center (btn_center),
    .data       (data),
    .anode      (anode),
    .seg        (seg),
    .dp         (dp),
    .scroll_idx (scroll_idx),
    .auto_mode  (auto_mode)
  );

  hex_scroll_viewer #(
    .DATA_W      (16),
    .DIGITS      (4),
    .REFRESH_DIV (4),
    .AUTO_DIV    (16)
  ) dut_small (
    .clk        (clk),
    .rst        (rst),
    .btn_right  (btn_right),
    .btn_left   (btn_left),
    .btn_center (btn_center),
    .data       (data[15:0]),
    .anode      (s_anode),
    .seg        (s_seg),
    .dp         (s_dp),
    .scroll_idx (s_idx),
    .auto_mode  (s_auto)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  anode;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs[20];
  vec_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_anode(input logic [3:0] target);
    int n = 0;
    while (anode !== target && n < 40) begin
      tick();
      n++;
    end
    chk("anode_reach", {28'h0, anode}, {28'h0, target});
  endtask

  task automatic press(input int which);
    if (which == 0) btn_right = 1'b1;
    else            btn_left  = 1'b1;
    tick();
    btn_right = 1'b0;
    btn_left  = 1'b0;
    tick();
  endtask

  function automatic logic exp_dp(input logic [3:0] an, input int idx);
`ifdef HEX_SCROLL_DP_EN
    if (an == 4'b0111 && idx < 4) return 1'b0;
    if (an == 4'b1110 && idx > 0) return 1'b0;
    return 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx_m;
    logic [6:0] exp_seg[4];
    logic [3:0] an_list[4];
    vec_t e;

    vecs[0]  = '{32'h0123ABCF, 4'b1110, 7'h0E};
    vecs[1]  = '{32'h0123ABCF, 4'b1101, 7'h46};
    vecs[2]  = '{32'h0123ABCF, 4'b1011, 7'h03};
    vecs[3]  = '{32'h0123ABCF, 4'b0111, 7'h08};
    vecs[4]  = '{32'h76543210, 4'b1110, 7'h40};
    vecs[5]  = '{32'h76543210, 4'b1101, 7'h79};
    vecs[6]  = '{32'h76543210, 4'b1011, 7'h24};
    vecs[7]  = '{32'h76543210, 4'b0111, 7'h30};
    vecs[8]  = '{32'hFEDCBA98, 4'b1110, 7'h00};
    vecs[9]  = '{32'hFEDCBA98, 4'b1101, 7'h10};
    vecs[10] = '{32'hFEDCBA98, 4'b1011, 7'h08};
    vecs[11] = '{32'hFEDCBA98, 4'b0111, 7'h03};
    vecs[12] = '{32'h00007654, 4'b1110, 7'h19};
    vecs[13] = '{32'h00007654, 4'b1101, 7'h12};
    vecs[14] = '{32'h00007654, 4'b1011, 7'h02};
    vecs[15] = '{32'h00007654, 4'b0111, 7'h78};
    vecs[16] = '{32'h00000DEC, 4'b1110, 7'h46};
    vecs[17] = '{32'h00000DEC, 4'b1101, 7'h06};
    vecs[18] = '{32'h00000DEC, 4'b1011, 7'h21};
    vecs[19] = '{32'h00000DEC, 4'b0111, 7'h40};

    an_list[0] = 4'b1110;
    an_list[1] = 4'b1101;
    an_list[2] = 4'b1011;
    an_list[3] = 4'b0111;

    // Reset state
    rst = 1'b1;
    btn_right = 1'b0;
    btn_left = 1'b0;
    btn_center = 1'b0;
    data = 32'h0123ABCF;
    tick();
    tick();
    chk("rst_anode", {28'h0, anode}, 32'hF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_dp", {31'h0, dp}, 32'h1);
    chk("rst_idx", {29'h0, scroll_idx}, 32'h0);
    chk("rst_auto", {31'h0, auto_mode}, 32'h0);
    rst = 1'b0;
    tick();
    chk("first_anode", {28'h0, anode}, 32'hE);

    // Table-driven digit walk at idx 0 with scoreboard
    for (int i = 0; i < 20; i++) begin
      data = vecs[i].data;
      exp_q.push_back(vecs[i]);
      wait_anode(vecs[i].anode);
      e = exp_q.pop_front();
      chk($sformatf("tbl%0d_seg", i), {25'h0, seg}, {25'h0, e.seg});
      chk($sformatf("tbl%0d_dp", i), {31'h0, dp}, {31'h0, exp_dp(e.anode, 0)});
    end

    // Manual scroll right with saturation
    data = 32'h76543210;
    idx_m = 0;
    for (int i = 0; i < 5; i++) begin
      press(0);
      if (idx_m < 4) idx_m++;
      chk($sformatf("right%0d_idx", i), {29'h0, scroll_idx}, idx_m);
    end
    chk("small_idx_right", {30'h0, s_idx}, 32'h0);
    wait_anode(4'b1110);
    chk("idx4_dig0_seg", {25'h0, seg}, 32'h19);
    wait_anode(4'b0111);
    chk("idx4_dig3_seg", {25'h0, seg}, 32'h78);

    // Manual scroll left with saturation
    for (int i = 0; i < 5; i++) begin
      press(1);
      if (idx_m > 0) idx_m--;
      chk($sformatf("left%0d_idx", i), {29'h0, scroll_idx}, idx_m);
    end

    // Held button gives one step; simultaneous left+right cancel
    btn_right = 1'b1;
    repeat (50) tick();
    btn_right = 1'b0;
    tick();
    chk("hold_idx", {29'h0, scroll_idx}, 32'h1);
    btn_right = 1'b1;
    btn_left = 1'b1;
    tick();
    chk("both_idx", {29'h0, scroll_idx}, 32'h1);
    btn_right = 1'b0;
    btn_left = 1'b0;
    tick();
    press(1);
    chk("back_to0", {29'h0, scroll_idx}, 32'h0);

    // Center + right together: only the toggle
    btn_center = 1'b1;
    btn_right = 1'b1;
    tick();
    btn_center = 1'b0;
    btn_right = 1'b0;
    chk("auto_on", {31'h0, auto_mode}, 32'h1);
    chk("auto_on_idx", {29'h0, scroll_idx}, 32'h0);
    chk("small_auto_on", {31'h0, s_auto}, 32'h1);

    // Auto scroll every 16 cycles, wrapping 4 -> 0; right pulses ignored
    idx_m = 0;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 15; j++) begin
        if (k == 1 && j == 3) btn_right = 1'b1;
        if (k == 1 && j == 6) btn_right = 1'b0;
        tick();
      end
      chk($sformatf("auto%0d_hold", k), {29'h0, scroll_idx}, idx_m);
      tick();
      idx_m = (idx_m + 1) % 5;
      chk($sformatf("auto%0d_step", k), {29'h0, scroll_idx}, idx_m);
    end
    chk("small_idx_auto", {30'h0, s_idx}, 32'h0);

    // Second center: back to manual, index frozen
    repeat (5) tick();
    btn_center = 1'b1;
    tick();
    btn_center = 1'b0;
    chk("auto_off", {31'h0, auto_mode}, 32'h0);
    repeat (40) tick();
    chk("frozen_idx", {29'h0, scroll_idx}, 32'h1);

    // Reset in the middle of auto scrolling
    btn_center = 1'b1;
    tick();
    btn_center = 1'b0;
    repeat (32) tick();
    chk("pre_rst_idx", {29'h0, scroll_idx}, 32'h3);
    wait_anode(4'b1011);
    chk("pre_rst_auto", {31'h0, auto_mode}, 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_idx", {29'h0, scroll_idx}, 32'h0);
    chk("mid_rst_auto", {31'h0, auto_mode}, 32'h0);
    chk("mid_rst_anode", {28'h0, anode}, 32'hF);
    chk("mid_rst_seg", {25'h0, seg}, 32'h7F);
    chk("mid_rst_dp", {31'h0, dp}, 32'h1);
    rst = 1'b0;
    tick();
    chk("post_rst_anode", {28'h0, anode}, 32'hE);
    repeat (40) tick();
    chk("post_rst_idx", {29'h0, scroll_idx}, 32'h0);
    chk("post_rst_auto", {31'h0, auto_mode}, 32'h0);

    // Decimal points and segments at idx 2
    press(0);
    press(0);
    chk("idx2", {29'h0, scroll_idx}, 32'h2);
    exp_seg[0] = 7'h24;
    exp_seg[1] = 7'h30;
    exp_seg[2] = 7'h19;
    exp_seg[3] = 7'h12;
    for (int d = 0; d < 4; d++) begin
      wait_anode(an_list[d]);
      chk($sformatf("idx2_seg%0d", d), {25'h0, seg}, {25'h0, exp_seg[d]});
      chk($sformatf("idx2_dp%0d", d), {31'h0, dp}, {31'h0, exp_dp(an_list[d], 2)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
